// File: rtl/branch_predictor_pkg.sv
// Shared constants for the branch predictor: word size, counter encodings,
// default table geometry and the misprediction test.
package branch_predictor_pkg;

  localparam int WORD_SIZE          = 16;
  localparam int BTB_INDEX_BITS_DEF = 8;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  // A resolved instruction was mispredicted if the direction differs, or if
  // it was taken and the carried prediction went somewhere else.
  function automatic logic is_mispredict(
    input logic                 taken,
    input logic [WORD_SIZE-1:0] target,
    input logic                 pred_taken,
    input logic [WORD_SIZE-1:0] pred_target
  );
    return (taken != pred_taken) || (taken && (target != pred_target));
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating up/down counter next-state logic (no storage).
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       up,
  output logic [1:0] nxt
);

  // Step toward ST on up, toward SNT otherwise, holding at either end.
  always_comb begin
    nxt = ctr;
    if (up) begin
      if (ctr != CTR_ST)  nxt = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) nxt = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters. Zero-latency lookup on
// pc_IF, one update per cycle from the resolution stage, saturating
// misprediction counter.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int BTB_INDEX_BITS = BTB_INDEX_BITS_DEF,
  parameter int PREDICTOR_EN   = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] pc_IF,
  output logic [WORD_SIZE-1:0] next_pc,
  output logic                 pred_taken,
  input  logic                 update_en,
  input  logic [WORD_SIZE-1:0] update_pc,
  input  logic [WORD_SIZE-1:0] update_target,
  input  logic                 update_taken,
  input  logic                 update_is_jump,
  input  logic                 update_pred_taken,
  input  logic [WORD_SIZE-1:0] update_pred_target,
  output logic [WORD_SIZE-1:0] miss_count
);

  localparam int  ENTRIES = 1 << BTB_INDEX_BITS;
  localparam int  TAG_W   = WORD_SIZE - BTB_INDEX_BITS;
  localparam bit  EN      = (PREDICTOR_EN != 0);

  logic [ENTRIES-1:0]                valid;
  logic [ENTRIES-1:0][TAG_W-1:0]     tag;
  logic [ENTRIES-1:0][WORD_SIZE-1:0] target;
  logic [ENTRIES-1:0]                is_jump;
  logic [ENTRIES-1:0][1:0]           ctr;

  logic [BTB_INDEX_BITS-1:0] if_idx, up_idx;
  logic [TAG_W-1:0]          if_tag, up_tag;
  logic                      if_hit, up_hit, up_alloc, wr_en, miss;
  logic [1:0]                up_ctr_nxt;

  assign if_idx = pc_IF[BTB_INDEX_BITS-1:0];
  assign if_tag = pc_IF[WORD_SIZE-1:BTB_INDEX_BITS];
  assign up_idx = update_pc[BTB_INDEX_BITS-1:0];
  assign up_tag = update_pc[WORD_SIZE-1:BTB_INDEX_BITS];

  // Lookup: reads registered state only, so a same-cycle update is not seen.
  always_comb begin
    if_hit     = valid[if_idx] && (tag[if_idx] == if_tag);
    pred_taken = EN && if_hit && (is_jump[if_idx] || ctr[if_idx] >= CTR_WT);
    next_pc    = pred_taken ? target[if_idx] : pc_IF + 16'd1;
  end

  // Only taken branches or jumps earn an entry; a not-taken miss leaves it alone.
  assign wr_en    = EN && update_en;
  assign up_hit   = valid[up_idx] && (tag[up_idx] == up_tag);
  assign up_alloc = !up_hit && (update_taken || update_is_jump);
  assign miss     = is_mispredict(update_taken, update_target,
                                  update_pred_taken, update_pred_target);

  // One counter step per update path, shared by every entry.
  sat_counter2 u_ctr (
    .ctr (ctr[up_idx]),
    .up  (update_taken),
    .nxt (up_ctr_nxt)
  );

  // Table write: train on hit, replace on allocating miss, clear on reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid[i] <= 1'b0;
        ctr[i]   <= CTR_WNT;
      end
    end else if (wr_en) begin
      if (up_hit) begin
        ctr[up_idx]     <= up_ctr_nxt;
        is_jump[up_idx] <= update_is_jump;
        if (update_taken) target[up_idx] <= update_target;
      end else if (up_alloc) begin
        valid[up_idx]   <= 1'b1;
        tag[up_idx]     <= up_tag;
        target[up_idx]  <= update_target;
        is_jump[up_idx] <= update_is_jump;
        ctr[up_idx]     <= update_taken ? CTR_WT : CTR_WNT;
      end
    end
  end

  // Misprediction counter, sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!reset_n)                                  miss_count <= '0;
    else if (wr_en && miss && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
  end

endmodule
